mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Single-port word memory that responds to the multicycle MIPS core's memory requests.
//  Uses a req/ready/rvalid handshake with a programmable number of wait states.
//  Sits between the datapath (Adr, WriteData, ReadData) and backing storage.
//  The controller FSM stalls in its MemRead/MemWrite states until rvalid.
// PARAMETERS
//  DEPTH   64  number of 32-bit words; power of two, 4..4096
//  WAIT    2   wait states between accept and response, 0..15
//  AW      $clog2(DEPTH)  word-index width; derived, not overridden
// PORTS
//  clk     in   1   rising-edge clock, sole clock
//  reset   in   1   synchronous, active-low (0 = reset), sampled on posedge clk
//  req     in   1   request valid
//  we      in   1   1 = write, 0 = read; sampled with req
//  be      in   4   byte enables for writes; be[i] enables wdata[8i+7:8i]
//  addr    in   32  byte address
//  wdata   in   32  write data
//  ready   out  1   responder can accept a request this cycle
//  rvalid  out  1   one-cycle response strobe
//  rdata   out  32  read data, valid when rvalid
//  err     out  1   request faulted, valid when rvalid
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE, wait counter 0, ready=1, rvalid=0, rdata=0,
//    err=0. Array contents are not reset.
//  - FSM:
//    - IDLE: ready=1. On req, capture we/be/addr/wdata. Go to WAIT if WAIT>0, else RESP.
//    - WAIT: ready=0. Counter runs WAIT-1..0. At 0, go to RESP.
//    - RESP: ready=0, rvalid=1 for exactly one cycle. Then go to IDLE.
//  - Latency: a request accepted at edge N gives rvalid high during cycle N+WAIT+1.
//    Minimum request spacing is WAIT+2 cycles.
//  - Captured request fields are used throughout. Input changes after acceptance are ignored.
//    req while ready=0 is ignored and not queued.
//  - Commit: write and read happen on the edge that enters RESP. rdata and err are
//    registered on that edge and stay stable through RESP.
//  - Commit results:
//    - Read: rdata = mem[addr[AW+1:2]].
//    - Write: updates only enabled lanes; rdata = 0.
//    - be=4'b0000 write: no change, normal response.
//    - be is ignored on reads.
//  - Fault: err=1 if addr[1:0]!=2'b00 or addr[31:2]>=DEPTH. On fault: no array update,
//    rdata=0, response timing unchanged.
//  - Read-after-write: a read issued after the write's rvalid returns the new data.
//  - rdata and err return to 0 in IDLE/WAIT, so they are 0 when rvalid=0.
//  - Reset mid-operation:
//    - Reset before the RESP-entry edge aborts the request; no write commits.
//    - Reset during RESP does not undo a write already committed.
//  - Simultaneous reset and req: reset wins; the request is dropped.
// STRUCTURE
//  - Package mem_pkg:
//    - typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} mem_state_t
//    - localparam WORD_W = 32, BE_W = 4
//    - function addr_fault(addr, depth)
//  - Sub-module bytelane_ram #(DEPTH): four 8-bit lanes with per-lane write enable,
//    synchronous read.
//  - Top level holds the FSM, capture registers and wait counter.
// TESTING
//  1. Reset, then read.
//     - Hold reset=0 for 2 cycles: ready=1, rvalid=0, rdata=0, err=0.
//     - Release reset; read addr 0x10 after preload mem[4]=0xDEADBEEF.
//     - Required: rvalid in cycle accept+3 (WAIT=2), rdata=0xDEADBEEF, err=0.
//  2. Byte-lane write.
//     - mem[1]=0x11223344; write addr 0x4, be=4'b0101, wdata=0xAABBCCDD.
//     - Read addr 0x4 afterwards: required rdata=0x11BB33DD.
//  3. Fault cases (DEPTH=64).
//     - Read addr 0x102: required err=1, rdata=0.
//     - Write addr 0x100: required err=1; mem[63] and mem[0] unchanged.
//  4. Ignored and held inputs.
//     - req asserted continuously: a new accept exactly every WAIT+2 cycles.
//     - Change addr/wdata during WAIT: the response uses the captured values.
//  5. Zero wait states (WAIT=0).
//     - rvalid in the cycle after accept.
//     - Write 0x5 to 0x8, then read 0x8: required 0x00000005.
//  6. Reset mid-operation.
//     - Accept a write to 0xC (wdata 0xCAFEF00D), assert reset during WAIT.
//     - Required: no rvalid, mem[3] unchanged, ready=1 after reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the mem_responder slice.
//   mem_state_t  : responder FSM encoding (IDLE / WAIT / RESP)
//   WORD_W, BE_W : data word width and number of byte lanes
//   addr_fault() : 1 when a byte address is unaligned or beyond the array
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } mem_state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // Word index is addr[31:2]; anything at or past depth is out of range.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/bytelane_ram.sv
// Word memory split into BE_W independent 8-bit lanes.
//   clk       : rising-edge clock
//   i_en      : access strobe; read and lane writes happen only when set
//   i_lane_we : per-lane write enable (qualified by i_en)
//   i_idx     : word index
//   i_wdata   : write data, lane g = i_wdata[8g+7:8g]
//   o_rdata   : registered read data (old contents on a write access)
// Contents are never reset.
module bytelane_ram
  import mem_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [BE_W-1:0]   i_lane_we,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  for (genvar g = 0; g < BE_W; g++) begin : g_lane
    logic [7:0] r_lane [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_en) begin
        if (i_lane_we[g]) r_lane[i_idx] <= i_wdata[8*g +: 8];
        r_q <= r_lane[i_idx];
      end
    end

    assign o_rdata[8*g +: 8] = r_q;
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port word memory answering req/ready/rvalid requests after WAIT
// wait states.
//   clk, reset  : clock; synchronous active-low reset
//   req, we, be : request valid, write select, byte enables
//   addr, wdata : byte address, write data
//   ready       : a request is accepted on the next edge if req is high
//   rvalid      : one-cycle response strobe; rdata/err are valid with it
//   rdata, err  : read data (0 for writes/faults), fault flag
//   o_dbg_state : current FSM state for observation
// Handshake: a request transfers on a rising edge where req && ready (and
// reset is released). Exactly one rvalid pulse follows every accepted
// request, WAIT+1 cycles later; req while ready==0 is dropped, never queued.
module mem_responder
  import mem_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int WAIT  = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [WORD_W-1:0] rdata,
  output logic              err,
  output mem_state_t        o_dbg_state
);

  mem_state_t        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_rd_sel;   // response carries array read data

  logic              w_use_in;
  logic              w_we;
  logic [BE_W-1:0]   w_be;
  logic [31:0]       w_addr;
  logic [WORD_W-1:0] w_wdata;
  logic              w_fault;
  logic              w_commit;
  logic [BE_W-1:0]   w_lane_we;
  logic [WORD_W-1:0] w_ram_q;

  // With zero wait states the commit edge is the accept edge, so the request
  // must come straight from the inputs; otherwise from the capture registers.
  assign w_use_in = (r_state == S_IDLE);
  assign w_we     = w_use_in ? we    : r_we;
  assign w_be     = w_use_in ? be    : r_be;
  assign w_addr   = w_use_in ? addr  : r_addr;
  assign w_wdata  = w_use_in ? wdata : r_wdata;
  assign w_fault  = addr_fault(w_addr, DEPTH);

  // Edge that enters RESP; reset low suppresses it so no write commits.
  assign w_commit = reset &&
                    (((r_state == S_IDLE) && req && (WAIT == 0)) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd0)));

  assign w_lane_we = (w_we && !w_fault) ? w_be : '0;

  bytelane_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .i_en      (w_commit),
    .i_lane_we (w_lane_we),
    .i_idx     (w_addr[AW+1:2]),
    .i_wdata   (w_wdata),
    .o_rdata   (w_ram_q)
  );

  // RAM output is held outside commits; the registered select forces 0
  // outside RESP and for write/fault responses.
  assign rdata       = w_ram_q & {WORD_W{r_rd_sel}};
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd_sel <= 1'b0;
      ready    <= 1'b1;
      rvalid   <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_be    <= be;
            r_addr  <= addr;
            r_wdata <= wdata;
            ready   <= 1'b0;
            if (WAIT == 0) begin
              r_state  <= S_RESP;
              rvalid   <= 1'b1;
              err      <= w_fault;
              r_rd_sel <= !w_we && !w_fault;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_RESP;
            rvalid   <= 1'b1;
            err      <= w_fault;
            r_rd_sel <= !w_we && !w_fault;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          ready    <= 1'b1;
          rvalid   <= 1'b0;
          err      <= 1'b0;
          r_rd_sel <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          ready    <= 1'b1;
          rvalid   <= 1'b0;
          err      <= 1'b0;
          r_rd_sel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WAIT=2 instance
  logic        req2 = 0, we2 = 0;
  logic [3:0]  be2 = 0;
  logic [31:0] addr2 = 0, wdata2 = 0;
  logic        ready2, rvalid2, err2;
  logic [31:0] rdata2;
  mem_state_t  st2;

  // WAIT=0 instance
  logic        req0 = 0, we0 = 0;
  logic [3:0]  be0 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0;
  logic        ready0, rvalid0, err0;
  logic [31:0] rdata0;
  mem_state_t  st0;

  mem_responder #(.DEPTH(64), .WAIT(2)) u_dut (
    .clk(clk), .reset(rst_n), .req(req2), .we(we2), .be(be2), .addr(addr2),
    .wdata(wdata2), .ready(ready2), .rvalid(rvalid2), .rdata(rdata2),
    .err(err2), .o_dbg_state(st2)
  );

  mem_responder #(.DEPTH(64), .WAIT(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .req(req0), .we(we0), .be(be0), .addr(addr0),
    .wdata(wdata0), .ready(ready0), .rvalid(rvalid0), .rdata(rdata0),
    .err(err0), .o_dbg_state(st0)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Selected instance view (0 = WAIT=2 dut, 1 = WAIT=0 dut)
  bit sel = 0;
  wire        c_ready  = sel ? ready0  : ready2;
  wire        c_rvalid = sel ? rvalid0 : rvalid2;
  wire [31:0] c_rdata  = sel ? rdata0  : rdata2;
  wire        c_err    = sel ? err0    : err2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s, input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    if (s) begin req0 = r; we0 = w; be0 = b; addr0 = a; wdata0 = d; end
    else   begin req2 = r; we2 = w; be2 = b; addr2 = a; wdata2 = d; end
  endtask

  // One request; lat counts negedges from the accept edge to rvalid.
  task automatic txn(input bit s, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat);
    int n;
    sel = s;
    @(negedge clk);
    n = 0;
    while (!c_ready && n < 20) begin @(negedge clk); n++; end
    drive(s, 1'b1, w, b, a, d);
    @(negedge clk);
    drive(s, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    lat = 1;
    while (!c_rvalid && lat < 20) begin @(negedge clk); lat++; end
    rd = c_rdata;
    e  = c_err;
  endtask

  task automatic wr(input string tag, input bit s, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] b, input logic exp_err);
    logic [31:0] rd; logic e; int lat;
    txn(s, 1'b1, b, a, d, rd, e, lat);
    chk({tag, "_lat"}, 32'(lat), s ? 32'd1 : 32'd3);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    chk({tag, "_rdata"}, rd, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input bit s, input logic [31:0] a,
                        input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd; logic e; int lat;
    txn(s, 1'b0, 4'hF, a, 32'h0, rd, e, lat);
    chk({tag, "_lat"}, 32'(lat), s ? 32'd1 : 32'd3);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    chk({tag, "_rdata"}, rd, exp);
  endtask

  initial begin
    int pulses;
    int first;
    int last;
    logic ok_space;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready",  {31'b0, ready2},  32'd1);
    chk("rst_rvalid", {31'b0, rvalid2}, 32'd0);
    chk("rst_rdata",  rdata2,           32'd0);
    chk("rst_err",    {31'b0, err2},    32'd0);
    chk("rst_state",  32'(st2),         32'(S_IDLE));
    chk("rst_ready0", {31'b0, ready0},  32'd1);
    rst_n = 1'b1;

    // ---------------- 1. preload then read ----------------
    wr("pre4", 0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    rd_chk("rd10", 0, 32'h10, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    chk("post_rvalid", {31'b0, rvalid2}, 32'd0);
    chk("post_rdata",  rdata2,           32'd0);
    chk("post_ready",  {31'b0, ready2},  32'd1);

    // ---------------- 2. byte-lane write ----------------
    wr("pre1", 0, 32'h4, 32'h11223344, 4'hF, 1'b0);
    wr("lane", 0, 32'h4, 32'hAABBCCDD, 4'b0101, 1'b0);
    rd_chk("rd4", 0, 32'h4, 32'h11BB33DD, 1'b0);
    wr("be0", 0, 32'h10, 32'h01020304, 4'b0000, 1'b0);
    rd_chk("rd10_be0", 0, 32'h10, 32'hDEADBEEF, 1'b0);

    // ---------------- 3. faults ----------------
    wr("pre63", 0, 32'hFC, 32'h63636363, 4'hF, 1'b0);
    wr("pre0",  0, 32'h0,  32'h00000A0A, 4'hF, 1'b0);
    rd_chk("rd102", 0, 32'h102, 32'h0, 1'b1);
    wr("wr100", 0, 32'h100, 32'hFFFFFFFF, 4'hF, 1'b1);
    wr("wr_unal", 0, 32'h1, 32'hFFFFFFFF, 4'hF, 1'b1);
    rd_chk("rd63", 0, 32'hFC, 32'h63636363, 1'b0);
    rd_chk("rd0",  0, 32'h0,  32'h00000A0A, 1'b0);

    // ---------------- 4a. continuous req ----------------
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    pulses = 0; first = -1; last = -1; ok_space = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (rvalid2) begin
        if (last >= 0 && (i - last) != 4) ok_space = 1'b0;
        if (first < 0) first = i;
        last = i;
        pulses++;
        chk("cont_rdata", rdata2, 32'hDEADBEEF);
      end
    end
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("cont_pulses", 32'(pulses), 32'd3);
    chk("cont_first",  32'(first),  32'd3);
    chk("cont_space",  {31'b0, ok_space}, 32'd1);
    repeat (4) @(negedge clk);

    // ---------------- 4b. inputs changed during WAIT ----------------
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk);                                   // accepted, now WAIT
    drive(0, 1'b1, 1'b1, 4'hF, 32'h4, 32'h55555555);  // ignored
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 4'hF, 32'h4, 32'h55555555);
    @(negedge clk);
    chk("hold_rvalid", {31'b0, rvalid2}, 32'd1);
    chk("hold_rdata",  rdata2,           32'hDEADBEEF);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rd_chk("hold_rd4", 0, 32'h4, 32'h11BB33DD, 1'b0);

    // ---------------- 5. zero wait states ----------------
    wr("z_wr8", 1, 32'h8, 32'h00000005, 4'hF, 1'b0);
    rd_chk("z_rd8", 1, 32'h8, 32'h00000005, 1'b0);
    rd_chk("z_rd102", 1, 32'h102, 32'h0, 1'b1);

    // ---------------- 6. reset mid-operation ----------------
    wr("preC", 0, 32'hC, 32'h12345678, 4'hF, 1'b0);
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'hF, 32'hC, 32'hCAFEF00D);
    @(negedge clk);                                   // accepted, in WAIT
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("mid_state", 32'(st2), 32'(S_WAIT));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rvalid", {31'b0, rvalid2}, 32'd0);
    chk("mid_ready",  {31'b0, ready2},  32'd1);
    rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid2) pulses++;
    end
    chk("mid_no_rvalid", 32'(pulses), 32'd0);
    rd_chk("mid_rdC", 0, 32'hC, 32'h12345678, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
